useq_branch_sequencer: RTL
==========================

# useq_branch_sequencer

Microprogram sequencer that consumes the processor status flags {C,V,Z,N} produced by the status register. It evaluates 16 branch conditions against those flags and drives the microprogram counter (uPC) that addresses the control store. It supports sequential, jump, conditional branch, call/return (small return stack) and hold operations. It also stalls one cycle when a conditional branch coincides with a flag update, so it always branches on the updated flags.

## Interface
- USEQ_ADDR, 8: uPC / target address width
- USEQ_PSR, 4: flag bus width (fixed 4)
- USEQ_DEPTH, 4: return-stack entries
- USEQ_CLOCK_50  input  1  system clock, rising edge
- USEQ_ResetInLow_In  input  1  reset, asynchronous, active-low
- USEQ_Psr_InBus  input  4  registered flags: bit3=C, bit2=V, bit1=Z, bit0=N
- USEQ_SetCodesPending_In  input  1  flag-update strobe; high means the flags change at the next edge
- USEQ_Enable_In  input  1  sequencer advance enable
- USEQ_Op_InBus  input  3  000 NEXT, 001 JUMP, 010 BCOND, 011 CALL, 100 RET, 101 HOLD, 110/111 treated as NEXT
- USEQ_Cond_InBus  input  4  condition select for BCOND
- USEQ_Target_InBus  input  USEQ_ADDR  jump/branch/call target
- USEQ_uPC_OutBus  output  USEQ_ADDR  current microaddress (registered)
- USEQ_Taken_Out  output  1  registered pulse: previous edge loaded uPC non-sequentially
- USEQ_Stall_Out  output  1  registered; high while in WAIT
- USEQ_StackError_Out  output  1  sticky stack overflow/underflow flag

## Operation
- **Conditions, encoded 0x0–0xF:**
  - 0x0 EQ: Z; 0x1 NE: !Z; 0x2 CS: C; 0x3 CC: !C
  - 0x4 MI: N; 0x5 PL: !N; 0x6 VS: V; 0x7 VC: !V
  - 0x8 HI: C&!Z; 0x9 LS: !C|Z
  - 0xA GE: N==V; 0xB LT: N!=V
  - 0xC GT: !Z&(N==V); 0xD LE: Z|(N!=V)
  - 0xE AL: 1; 0xF NV: 0
- **FSM states:** RUN and WAIT.
- **RUN, Enable=1:**
  - NEXT: uPC <= uPC+1.
  - JUMP: uPC <= Target.
  - HOLD: uPC unchanged.
  - BCOND, SetCodesPending=0: uPC <= cond ? Target : uPC+1.
  - BCOND, SetCodesPending=1: uPC unchanged, next state WAIT. No evaluation this cycle.
  - CALL, stack not full: push uPC+1, uPC <= Target.
  - CALL, stack full: no push, StackError <= 1, uPC <= uPC+1.
  - RET, stack not empty: uPC <= top entry, pop.
  - RET, stack empty: StackError <= 1, uPC <= uPC+1.
- **WAIT, Enable=1:**
  - Upstream re-presents the same microword, because uPC held.
  - Evaluate BCOND with the current Psr, ignoring SetCodesPending. Load uPC as in RUN, then return to RUN.
  - If Op is not BCOND in WAIT, execute it as in RUN and return to RUN.
- **Enable=0:** uPC, state, stack, pointer and StackError all hold. Taken is 0 on the next edge.
- **Taken next edge:** 1 after JUMP, BCOND-taken, successful CALL, or successful RET; otherwise 0.
- **Return stack:** USEQ_DEPTH x USEQ_ADDR registers plus a pointer 0..USEQ_DEPTH (LIFO).
- **Width rules:** uPC+1 is modulo 2^USEQ_ADDR, so 0xFF+1 = 0x00; CALL at 0xFF pushes 0x00.
- **StackError:** clears only on reset.

## Timing
- **Reset (ResetInLow_In=0), immediate and independent of clock:**
  - uPC=0, Taken=0, Stall=0, StackError=0.
  - Stack pointer=0, state=RUN. Stack contents don't-care.
- Reset asserted mid-WAIT or mid-call-chain discards all state.
- **Latency:** the Op/Cond/Target presented in cycle t determine uPC after edge t+1.
- **BCOND hazard:** adds exactly one cycle. The uPC sequence is X, X(Stall=1), then target or X+1.
- Stall_Out is high for exactly the cycle the FSM is in WAIT.
- Psr_InBus is sampled only in the evaluation cycle. Flags are never latched internally.
- **Simultaneous CALL at full / RET at empty:** error set on the same edge that uPC advances by 1.

## Test plan
- **Reset mid-run:** run NEXT to uPC=0x25, pull ResetInLow_In low between edges -> uPC=0x00 and all outputs 0 at once; after release, NEXT gives 0x01, 0x02.
- **BCOND EQ:** at uPC=0x10, Target=0x40:
  - Psr=4'b0010 -> uPC=0x40, Taken=1 for one cycle.
  - Psr=4'b0000 -> uPC=0x11, Taken=0.
- **Hazard:** BCOND EQ at 0x10 with SetCodesPending=1 and Psr=0000; Psr becomes 0010 next edge -> cycle 1: uPC=0x10, Stall=1; cycle 2: uPC=0x40, Stall=0, Taken=1.
- **Signed/unsigned conditions:**
  - GE with N=1,V=1 -> taken.
  - LT with N=1,V=0 -> taken.
  - HI with C=1,Z=1 -> not taken; LS -> taken.
  - AL always taken; NV never taken.
- **Stack:** CALLs from 0x01, 0x11, 0x21, 0x31 -> pushes 0x02, 0x12, 0x22, 0x32.
  - Fifth CALL from 0x41 -> StackError=1, uPC=0x42.
  - Four RETs -> 0x32, 0x22, 0x12, 0x02.
  - Fifth RET -> error stays 1, uPC increments.
- **Wrap and enable:** NEXT at 0xFF -> 0x00; CALL at 0xFF, Target=0x80, then RET -> 0x00. Enable=0 for 3 cycles during WAIT -> uPC, Stall and state frozen; resumes correctly.

Source files
------------

// File: rtl/useq_branch_sequencer.sv
// Microprogram sequencer: drives the uPC from the NEXT/JUMP/BCOND/CALL/RET/HOLD ops,
// with a small return stack and a one-cycle stall when a branch meets a pending flag update.
module useq_branch_sequencer #(
  parameter int unsigned USEQ_ADDR  = 8,
  parameter int unsigned USEQ_PSR   = 4,
  parameter int unsigned USEQ_DEPTH = 4
) (
  input  logic                 USEQ_CLOCK_50,
  input  logic                 USEQ_ResetInLow_In,
  input  logic [USEQ_PSR-1:0]  USEQ_Psr_InBus,
  input  logic                 USEQ_SetCodesPending_In,
  input  logic                 USEQ_Enable_In,
  input  logic [2:0]           USEQ_Op_InBus,
  input  logic [3:0]           USEQ_Cond_InBus,
  input  logic [USEQ_ADDR-1:0] USEQ_Target_InBus,
  output logic [USEQ_ADDR-1:0] USEQ_uPC_OutBus,
  output logic                 USEQ_Taken_Out,
  output logic                 USEQ_Stall_Out,
  output logic                 USEQ_StackError_Out
);

  localparam int unsigned PW = $clog2(USEQ_DEPTH + 1);
  localparam int unsigned IW = (USEQ_DEPTH > 1) ? $clog2(USEQ_DEPTH) : 1;
  localparam logic [PW-1:0] SpFull = PW'(USEQ_DEPTH);

  typedef enum logic { ST_RUN, ST_WAIT } state_t;
  typedef enum logic [2:0] {
    OP_NEXT  = 3'b000,
    OP_JUMP  = 3'b001,
    OP_BCOND = 3'b010,
    OP_CALL  = 3'b011,
    OP_RET   = 3'b100,
    OP_HOLD  = 3'b101
  } op_t;

  state_t                 state, nextState;
  logic [USEQ_ADDR-1:0]   upc, nextUpc, upcInc, stackTop;
  logic                   taken, nextTaken, stackErr, setErr, doPush, doPop;
  logic [PW-1:0]          sp, spDec;
  logic [USEQ_ADDR-1:0]   stackMem [USEQ_DEPTH];
  logic                   flagC, flagV, flagZ, flagN, condMet;

  assign {flagC, flagV, flagZ, flagN} = USEQ_Psr_InBus[3:0];
  assign upcInc   = upc + 1'b1;
  assign spDec    = sp - 1'b1;
  assign stackTop = stackMem[spDec[IW-1:0]];

  always_comb begin
    condMet = 1'b0;
    case (USEQ_Cond_InBus)
      4'h0: condMet = flagZ;
      4'h1: condMet = !flagZ;
      4'h2: condMet = flagC;
      4'h3: condMet = !flagC;
      4'h4: condMet = flagN;
      4'h5: condMet = !flagN;
      4'h6: condMet = flagV;
      4'h7: condMet = !flagV;
      4'h8: condMet = flagC & !flagZ;
      4'h9: condMet = !flagC | flagZ;
      4'hA: condMet = (flagN == flagV);
      4'hB: condMet = (flagN != flagV);
      4'hC: condMet = !flagZ & (flagN == flagV);
      4'hD: condMet = flagZ | (flagN != flagV);
      4'hE: condMet = 1'b1;
      default: condMet = 1'b0;
    endcase
  end

  always_comb begin
    nextState = state;
    nextUpc   = upc;
    nextTaken = 1'b0;
    doPush    = 1'b0;
    doPop     = 1'b0;
    setErr    = 1'b0;
    if (USEQ_Enable_In) begin
      nextState = ST_RUN;
      case (USEQ_Op_InBus)
        OP_JUMP: begin
          nextUpc   = USEQ_Target_InBus;
          nextTaken = 1'b1;
        end
        OP_BCOND: begin
          // In WAIT the flags have settled, so the pending strobe is ignored.
          if (state == ST_RUN && USEQ_SetCodesPending_In) begin
            nextState = ST_WAIT;
          end else if (condMet) begin
            nextUpc   = USEQ_Target_InBus;
            nextTaken = 1'b1;
          end else begin
            nextUpc = upcInc;
          end
        end
        OP_CALL: begin
          if (sp != SpFull) begin
            doPush    = 1'b1;
            nextUpc   = USEQ_Target_InBus;
            nextTaken = 1'b1;
          end else begin
            setErr  = 1'b1;
            nextUpc = upcInc;
          end
        end
        OP_RET: begin
          if (sp != '0) begin
            doPop     = 1'b1;
            nextUpc   = stackTop;
            nextTaken = 1'b1;
          end else begin
            setErr  = 1'b1;
            nextUpc = upcInc;
          end
        end
        OP_HOLD: nextUpc = upc;
        default: nextUpc = upcInc;
      endcase
    end
  end

  always_ff @(posedge USEQ_CLOCK_50 or negedge USEQ_ResetInLow_In) begin
    if (!USEQ_ResetInLow_In) begin
      state    <= ST_RUN;
      upc      <= '0;
      taken    <= 1'b0;
      stackErr <= 1'b0;
      sp       <= '0;
    end else begin
      state <= nextState;
      upc   <= nextUpc;
      taken <= nextTaken;
      if (setErr) stackErr <= 1'b1;
      if (doPush)     sp <= sp + 1'b1;
      else if (doPop) sp <= spDec;
    end
  end

  always_ff @(posedge USEQ_CLOCK_50) begin
    if (doPush) stackMem[sp[IW-1:0]] <= upcInc;
  end

  assign USEQ_uPC_OutBus     = upc;
  assign USEQ_Taken_Out      = taken;
  assign USEQ_Stall_Out      = (state == ST_WAIT);
  assign USEQ_StackError_Out = stackErr;

endmodule
